// File: rtl/vec_pack_pkg.sv
// Shared types and helpers for the vector ALU pack/unpack stages.
// An AES state block is 16 bytes, column-major, with s0 in the top byte.
package vec_pack_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } unpack_state_t;

    // Byte at row r, column c is s[4c+r].
    // Left-shifting by 8*(4c+r) brings that byte to the top of the vector.
    function automatic logic [7:0] state_byte(input logic [127:0] s,
                                              input logic [1:0]   r,
                                              input logic [1:0]   c);
        logic [127:0] shifted;
        shifted = s << {c, r, 3'b000};
        return shifted[127:120];
    endfunction

endpackage

// File: rtl/state_transpose.sv
// Reorders a column-major AES state into row-major, so that each 32-bit word
// of the result holds one state row {s_r, s_r+4, s_r+8, s_r+12}.
module state_transpose
    import vec_pack_pkg::*;
(
    input  logic [127:0] col_state,
    output logic [127:0] row_state
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign row_state[127-8*(4*r+c) -: 8] = state_byte(col_state, 2'(r), 2'(c));
        end
    end

endmodule

// File: rtl/unpacking_unit.sv
// Splits one 128-bit AES state into two beats of lane operand pairs, in either
// column order or row order (MixColumns), over a valid/ready handshake.
module unpacking_unit #(
    parameter int LANE_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_state,
    input  logic              in_mc_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane0,
    output logic [LANE_W-1:0] out_lane1,
    output logic              out_last,
    output logic [CNT_W-1:0]  blk_count
);

    import vec_pack_pkg::*;

    unpack_state_t    state_q, state_d;
    logic [127:0]     buf_q, buf_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             out_hs;
    logic [127:0]     row_state;
    logic [127:0]     sel_state;

    // in_ready looks at out_ready directly so a new block can land in the
    // same cycle the final beat of the previous one drains.
    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == BEAT1) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == BEAT0) || (state_q == BEAT1);
    assign out_last  = (state_q == BEAT1);
    assign out_hs    = out_valid && out_ready;
    assign blk_count = cnt_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;

        if (accept) begin
            buf_d  = in_state;
            mode_d = in_mc_mode;
            cnt_d  = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE:    if (accept) state_d = BEAT0;
            BEAT0:   if (out_hs) state_d = BEAT1;
            BEAT1:   if (out_hs) state_d = accept ? BEAT0 : IDLE;
            default: state_d = IDLE;
        endcase

        // Flush wins over everything except the block counter.
        if (flush) begin
            state_d = IDLE;
            buf_d   = '0;
            mode_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    state_transpose u_transpose (
        .col_state (buf_q),
        .row_state (row_state)
    );

    assign sel_state = mode_q ? row_state : buf_q;

    // Lanes are zero whenever no beat is being presented.
    always_comb begin
        out_lane0 = '0;
        out_lane1 = '0;
        case (state_q)
            BEAT0: begin
                out_lane0 = sel_state[127:96];
                out_lane1 = sel_state[95:64];
            end
            BEAT1: begin
                out_lane0 = sel_state[63:32];
                out_lane1 = sel_state[31:0];
            end
            default: begin
                out_lane0 = '0;
                out_lane1 = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_unpacking_unit.sv
// Self-checking bench for unpacking_unit: directed scenarios plus a scoreboard
// that predicts every output beat from the blocks accepted.
module tb_unpacking_unit;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_mc_mode;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_lane0;
    logic [31:0]  out_lane1;
    logic         out_last;
    logic [7:0]   blk_count;

    int checks = 0;
    int errors = 0;

    logic [64:0] sbQueue[$];

    localparam logic [127:0] BLK   = 128'h0102030405060708090a0b0c0d0e0f10;
    localparam logic [127:0] BLK_B = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

    unpacking_unit #(.LANE_W(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_mc_mode (in_mc_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lane0  (out_lane0),
        .out_lane1  (out_lane1),
        .out_last   (out_last),
        .blk_count  (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference beat: {lane0, lane1, last}. Word w of a block is column w in
    // column mode, or row w = {s_w, s_w+4, s_w+8, s_w+12} in row mode.
    function automatic logic [64:0] expBeat(input logic [127:0] s, input logic rowMode, input int beat);
        logic [31:0] w [2];
        for (int lane = 0; lane < 2; lane++) begin
            int idx;
            idx = 2 * beat + lane;
            if (rowMode) begin
                for (int k = 0; k < 4; k++)
                    w[lane][31-8*k -: 8] = s[127-8*(idx+4*k) -: 8];
            end else begin
                w[lane] = s[127-32*idx -: 32];
            end
        end
        return {w[0], w[1], (beat == 1)};
    endfunction

    // Scoreboard: compare each consumed beat, then drop on flush, then
    // enqueue the beats of any block accepted at the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            sbQueue.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected_beat got %h/%h last=%b expected no beat", out_lane0, out_lane1, out_last);
                end else begin
                    logic [64:0] exp;
                    exp = sbQueue.pop_front();
                    if ({out_lane0, out_lane1, out_last} !== exp) begin
                        errors++;
                        $display("[TB] FAIL sb_beat got %h/%h last=%b expected %h/%h last=%b",
                                 out_lane0, out_lane1, out_last, exp[64:33], exp[32:1], exp[0]);
                    end
                end
            end
            if (flush) sbQueue.delete();
            if (in_valid && in_ready) begin
                sbQueue.push_back(expBeat(in_state, in_mc_mode, 0));
                sbQueue.push_back(expBeat(in_state, in_mc_mode, 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_last} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_flags got valid=%b last=%b expected 0 0", out_valid, out_last);
        end
        checks++;
        if ({out_lane0, out_lane1} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_lanes got %h/%h expected 0/0", out_lane0, out_lane1);
        end
        checks++;
        if (blk_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_count got %0d expected 0", blk_count);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
        step();
    endtask

    task automatic test_column();
        in_state = BLK; in_mc_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_state = '0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_lane0, out_lane1} !== {2'b10, 32'h01020304, 32'h05060708}) begin
            errors++;
            $display("[TB] FAIL col_beat0 got v=%b l=%b %h/%h expected v=1 l=0 01020304/05060708",
                     out_valid, out_last, out_lane0, out_lane1);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_lane0, out_lane1} !== {2'b11, 32'h090a0b0c, 32'h0d0e0f10}) begin
            errors++;
            $display("[TB] FAIL col_beat1 got v=%b l=%b %h/%h expected v=1 l=1 090a0b0c/0d0e0f10",
                     out_valid, out_last, out_lane0, out_lane1);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, blk_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL col_done got valid=%b count=%0d expected valid=0 count=1", out_valid, blk_count);
        end
        step();
    endtask

    task automatic test_row();
        in_state = BLK; in_mc_mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_mc_mode = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_lane0, out_lane1} !== {32'h0105090d, 32'h02060a0e}) begin
            errors++;
            $display("[TB] FAIL row_beat0 got %h/%h expected 0105090d/02060a0e", out_lane0, out_lane1);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_last, out_lane0, out_lane1} !== {1'b1, 32'h03070b0f, 32'h04080c10}) begin
            errors++;
            $display("[TB] FAIL row_beat1 got l=%b %h/%h expected l=1 03070b0f/04080c10", out_last, out_lane0, out_lane1);
        end
        step();
        @(negedge clk);
        checks++;
        if (blk_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL row_count got %0d expected 2", blk_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        in_state = BLK; in_mc_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_mc_mode = ~in_mc_mode;
            in_state   = ~BLK;
            @(negedge clk);
            checks++;
            if ({out_valid, out_last, in_ready, out_lane0, out_lane1} !== {3'b100, 32'h01020304, 32'h05060708}) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d got v=%b l=%b rdy=%b %h/%h expected v=1 l=0 rdy=0 01020304/05060708",
                         i, out_valid, out_last, in_ready, out_lane0, out_lane1);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_lane0, out_lane1} !== {32'h01020304, 32'h05060708}) begin
            errors++;
            $display("[TB] FAIL bp_release got %h/%h expected 01020304/05060708", out_lane0, out_lane1);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_last, out_lane0} !== {1'b1, 32'h090a0b0c}) begin
            errors++;
            $display("[TB] FAIL bp_beat1 got l=%b %h expected l=1 090a0b0c", out_last, out_lane0);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, blk_count} !== {1'b0, 8'd3}) begin
            errors++;
            $display("[TB] FAIL bp_done got valid=%b count=%0d expected valid=0 count=3", out_valid, blk_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        in_state = BLK; in_mc_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_state = BLK_B; in_mc_mode = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, in_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL b2b_a0 got v=%b l=%b rdy=%b expected 1 0 0", out_valid, out_last, in_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, in_ready} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL b2b_a1 got v=%b l=%b rdy=%b expected 1 1 1", out_valid, out_last, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_lane0} !== {2'b10, 32'hf0b4783c}) begin
            errors++;
            $display("[TB] FAIL b2b_b0 got v=%b l=%b %h expected v=1 l=0 f0b4783c", out_valid, out_last, out_lane0);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, out_last} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b_b1 got v=%b l=%b expected 1 1", out_valid, out_last);
        end
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, blk_count, sbQueue.size() == 0} !== {1'b0, 8'd5, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b2b_done got valid=%b count=%0d pending=%0d expected valid=0 count=5 pending=0",
                     out_valid, blk_count, sbQueue.size());
        end
        step();
    endtask

    task automatic test_flush();
        in_state = BLK; in_mc_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; in_valid = 1'b1; in_state = ~BLK;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, in_ready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL flush_cycle got v=%b l=%b rdy=%b expected 1 1 0", out_valid, out_last, in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, blk_count} !== {1'b0, 8'd6}) begin
            errors++;
            $display("[TB] FAIL flush_after got valid=%b count=%0d expected valid=0 count=6", out_valid, blk_count);
        end
        step();
    endtask

    task automatic test_count_wrap();
        int g;
        in_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (blk_count != 8'hff && g < 1200) begin
            in_state   = {$urandom, $urandom, $urandom, $urandom};
            in_mc_mode = 1'($urandom_range(0, 1));
            step();
            g++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_count !== 8'hff) begin
            errors++;
            $display("[TB] FAIL wrap_reach got %0d expected 255 (cycles %0d)", blk_count, g);
        end
        step();
        g = 0;
        while (out_valid && g < 10) begin
            step();
            g++;
        end
        in_state = BLK; in_mc_mode = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrap_zero got %0d expected 0", blk_count);
        end
        step();
        g = 0;
        while (out_valid && g < 10) begin
            step();
            g++;
        end
        @(negedge clk);
        checks++;
        if ({out_valid, sbQueue.size() == 0} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wrap_drain got valid=%b pending=%0d expected valid=0 pending=0", out_valid, sbQueue.size());
        end
        step();
    endtask

    task automatic test_reset_mid_block();
        in_state = BLK; in_mc_mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got valid=%b expected 1", out_valid);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_lane0, out_lane1, blk_count} !== 74'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_zero got v=%b l=%b %h/%h count=%0d expected all 0",
                     out_valid, out_last, out_lane0, out_lane1, blk_count);
        end
        @(negedge clk);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_no_partial got valid=%b expected 0", out_valid);
        end
        step();
        in_state = BLK; in_mc_mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_lane0, blk_count} !== {32'h01020304, 8'd1}) begin
            errors++;
            $display("[TB] FAIL rstmid_new got %h count=%0d expected 01020304 count=1", out_lane0, blk_count);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if ({out_valid, sbQueue.size() == 0} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstmid_drain got valid=%b pending=%0d expected valid=0 pending=0", out_valid, sbQueue.size());
        end
        step();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_state = '0;
        in_mc_mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_column();
        test_row();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_count_wrap();
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout reached without completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/unpacking_unit.md
# unpacking_unit

Splits one 128-bit AES state block into 32-bit ALU operand pairs, streamed as two beats over a valid/ready handshake. It is the front-end counterpart of the packing stage: the packer merges ALU lane results into half-rows, and this block hands the vector ALU's two lanes their word-granular operands. It can emit state columns or, in MixColumns mode, state rows, so the lanes see whichever orientation the next operation needs.

## Interface
- `LANE_W`, default 32: width of one ALU lane operand; fixed, and must equal 128/4.
- `CNT_W`, default 8: width of the accepted-block counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `flush`  in  1  synchronous abort of the block in flight.
- `in_valid`  in  1  a state block is offered.
- `in_ready`  out  1  the block will be accepted this cycle.
- `in_state`  in  128  state bytes s0..s15, s0 = [127:120], column-major (column c = s4c..s4c+3).
- `in_mc_mode`  in  1  0 = column order, 1 = row order (MixColumns).
- `out_valid`  out  1  lane operands are valid.
- `out_ready`  in  1  the ALU consumes the beat.
- `out_lane0`, `out_lane1`  out  LANE_W  operand words.
- `out_last`  out  1  marks beat 1, the final beat of a block.
- `blk_count`  out  CNT_W  number of blocks accepted since reset, wraps modulo 2^CNT_W.

## Operation
- Accept: a block is accepted when `in_valid && in_ready`. `in_state` and `in_mc_mode` are latched into an internal 128-bit buffer, and `blk_count` increments.
- Column mode:
  - beat 0: lane0 = col0, lane1 = col1.
  - beat 1: lane0 = col2, lane1 = col3.
- Row mode: row r = {s_r, s_r+4, s_r+8, s_r+12}.
  - beat 0: lane0 = row0, lane1 = row1.
  - beat 1: lane0 = row2, lane1 = row3.
- The latched mode governs the whole block. Changing `in_mc_mode` mid-block has no effect.
- FSM:
  - IDLE -> BEAT0 on accept.
  - BEAT0 -> BEAT1 on `out_valid && out_ready`.
  - BEAT1 -> BEAT0 on handshake with a simultaneous accept.
  - BEAT1 -> IDLE on handshake without an accept.
  - Any state -> IDLE on `flush`.
- `in_ready = !flush && (state==IDLE || (state==BEAT1 && out_ready))`. This combinational path from `out_ready` gives back-to-back blocks with no bubble.
- `out_valid = (state==BEAT0 || state==BEAT1)`. `out_last = (state==BEAT1)`.
- Outputs are driven from registered buffer and state, through a combinational beat/mode mux.
- Flush:
  - Drops the buffered block and blocks acceptance in that cycle.
  - `out_valid` is low in the next cycle.
  - `blk_count` is not decremented.
  - A flush coinciding with an output handshake still returns to IDLE.
- Backpressure: while `out_ready` is low, lanes, `out_last` and state hold stable.

## Timing
- Reset values:
  - state IDLE, buffer 0, latched mode 0.
  - `out_valid` 0, `out_last` 0.
  - `out_lane0`/`out_lane1` 0.
  - `blk_count` 0.
  - `in_ready` 1 once `rst` deasserts.
- Latency: block accepted at edge k; beat 0 is valid in cycle k+1; beat 1 follows one cycle after the beat-0 handshake.
- Throughput: 2 cycles per block under continuous `in_valid`/`out_ready`.
- Reset asserted mid-block: immediate return to reset values, the block is lost, and no partial beat is emitted afterward.
- `blk_count` at all-ones plus one accept gives 0.

## Structure
- Package `vec_pack_pkg`:
  - `LANE_W`.
  - enum `unpack_state_t {IDLE, BEAT0, BEAT1}`.
  - byte-index function `state_byte(s, r, c)`.
- Sub-module `state_transpose`: combinational 128-bit column-major to row-major byte permutation, instantiated on the buffer output. The mode mux selects between the raw and transposed buffer.

## Test plan
- Reset, then one block 0x0102030405060708090a0b0c0d0e0f10 in column mode, `out_ready`=1 -> beat 0 = 01020304 / 05060708 with last=0; beat 1 = 090a0b0c / 0d0e0f10 with last=1; `blk_count`=1.
- Same block in row mode -> beat 0 = 0105090d / 02060a0e; beat 1 = 03070b0f / 04080c10.
- `out_ready` low for 3 cycles during beat 0; mode toggled meanwhile -> lanes hold 01020304 / 05060708 with no mode change; `in_ready`=0 throughout.
- Two blocks back-to-back with `in_valid`=1 and `out_ready`=1 -> 4 consecutive valid beats, no idle cycle, `in_ready` high during each beat-1 handshake.
- `flush` during beat 1 with `in_valid`=1 -> no accept, `out_valid`=0 the next cycle, `blk_count` unchanged.
- Assert `rst` mid-beat-0, then accept a new block -> all outputs 0 during reset; the new block is emitted correctly.
